spi_xfer_ctrl: RTL and testbench
================================

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 SHALL: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL: start  in  1  start pulse; sampled only in IDLE.
REQ-004 SHALL: abort  in  1  abort pulse; honoured in any state.
REQ-005 SHALL: cmd_len  in  6  command bits, 0..32; values above 32 clamp to 32.
REQ-006 SHALL: cmd_data  in  32  command word, MSB-aligned.
REQ-007 SHALL: addr_len  in  6  address bits, 0..32; values above 32 clamp to 32.
REQ-008 SHALL: addr_data  in  32  address word, MSB-aligned.
REQ-009 SHALL: dummy_len  in  16  dummy SCK cycles, 0..65535.
REQ-010 SHALL: data_len  in  16  data bits, 0..65535.
REQ-011 SHALL: quad_en  in  1  quad mode for ADDR and DATA phases.
REQ-012 SHALL: cs_sel  in  2  chip-select index.
REQ-013 SHALL: wr_data/wr_valid/wr_ready  in/in/out  32/1/1  upstream data stream, valid/ready.
REQ-014 SHALL: tx_en, tx_en_quad, tx_cnt_upd  out  1 each  serializer control.
REQ-015 SHALL: tx_cnt  out  16  serializer target length in bits.
REQ-016 SHALL: tx_data/tx_data_valid  out  32/1  serializer word; tx_data_ready  in  1.
REQ-017 SHALL: tx_done  in  1  serializer last-edge strobe.
REQ-018 SHALL: csn  out  4  active-low chip selects.
REQ-019 SHALL: busy  out  1  high outside IDLE.
REQ-020 SHALL: done  out  1  one-cycle completion pulse.

Function
REQ-021 SHALL: FSM states IDLE, CMD, ADDR, DUMMY, DATA, END; each of CMD..DATA has a SETUP sub-cycle then a RUN sub-state.
REQ-022 SHALL: IDLE + start -> latch every config input, assert csn[cs_sel]=0 next cycle, enter first phase with non-zero length in order CMD, ADDR, DUMMY, DATA; all lengths zero -> END.
REQ-023 SHALL: SETUP, 1 cycle: tx_cnt_upd=1, tx_cnt = phase length, tx_en_quad = latched quad_en for ADDR/DATA, 0 for CMD/DUMMY; tx_data_valid=0.
REQ-024 SHALL: RUN: tx_en=1; tx_en_quad held.
REQ-025 SHALL: RUN data source: CMD presents cmd_data; ADDR presents addr_data; DUMMY presents 32'h0; each phase offers ceil(len/32) words.
REQ-026 SHALL: DATA forwards wr_data -> tx_data and wr_valid -> tx_data_valid; wr_ready = tx_data_ready, combinational, gated by words-remaining != 0.
REQ-027 SHALL: word counter decrements on tx_data_valid && tx_data_ready; tx_data_valid=0 once it reaches 0.
REQ-028 SHALL: RUN exits on tx_done -> next non-zero phase SETUP, else END; a phase never exits before tx_done.
REQ-029 SHALL: DATA in quad mode ignores data_len[1:0]; if the result is 0, DATA is skipped.
REQ-030 SHALL: END, 1 cycle: csn held low; next cycle csn=4'hF, done=1, state IDLE.
REQ-031 SHALL: start while busy is ignored.
REQ-032 SHALL: abort in any non-IDLE state, next cycle: IDLE, csn=4'hF, all tx_* low, wr_ready low, no done pulse; abort together with start in IDLE -> remain IDLE.
REQ-033 SHALL: only one csn bit is ever low; the selection is fixed for the whole transaction.
REQ-034 SHALL: tx_cnt_upd is never asserted while tx_en=1.

Reset
REQ-035 SHALL: rst asserted at any time, including mid-transaction: IDLE immediately; csn=4'hF; busy, done, tx_en, tx_en_quad, tx_cnt_upd, tx_data_valid, wr_ready = 0; tx_cnt, tx_data = 0; counters cleared.
REQ-036 SHALL: after rst deasserts, the block is idle until the next start.

Verification
REQ-037 SHALL: cmd_len=8, cmd_data=32'h9F000000, others 0, cs_sel=1 -> csn=4'b1101; one SETUP with tx_cnt=8; one word 9F000000; done 2 cycles after tx_done.
REQ-038 SHALL: cmd 8, addr_len=24, quad_en=1, dummy 8, data_len=64 -> tx_en_quad sequence 0,1,0,1; tx_cnt values 8,24,8,64; exactly 2 wr handshakes.
REQ-039 SHALL: all lengths 0 -> csn low for exactly 2 cycles, done pulse, no tx_en.
REQ-040 SHALL: abort during DATA after the first word -> next cycle csn=4'hF, tx_en=0, wr_ready=0, done stays 0.
REQ-041 SHALL: rst pulsed during ADDR -> all outputs at reset values asynchronously; a following start completes normally.
REQ-042 SHALL: DATA with wr_valid low for 5 cycles mid-phase -> tx_data_valid tracks wr_valid; word count stays exact; csn held low throughout.

Source files
------------

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: sequences one SPI transaction (CMD, ADDR, DUMMY, DATA) and
// drives an external serializer through setup/run handshakes. Each active
// phase spends one SETUP cycle loading the serializer length, then runs until
// the serializer reports its last edge. A one-cycle chip-select lead-in
// precedes the first phase so csn is settled before any serializer activity.
module spi_xfer_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [5:0]  cmd_len_i,
  input  logic [31:0] cmd_data_i,
  input  logic [5:0]  addr_len_i,
  input  logic [31:0] addr_data_i,
  input  logic [15:0] dummy_len_i,
  input  logic [15:0] data_len_i,
  input  logic        quad_en_i,
  input  logic [1:0]  cs_sel_i,
  input  logic [31:0] wr_data_i,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  output logic        tx_en_o,
  output logic        tx_en_quad_o,
  output logic        tx_cnt_upd_o,
  output logic [15:0] tx_cnt_o,
  output logic [31:0] tx_data_o,
  output logic        tx_data_valid_o,
  input  logic        tx_data_ready_i,
  input  logic        tx_done_i,
  output logic [3:0]  csn_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEAD,
    S_CMD_SETUP, S_CMD_RUN,
    S_ADDR_SETUP, S_ADDR_RUN,
    S_DUMMY_SETUP, S_DUMMY_RUN,
    S_DATA_SETUP, S_DATA_RUN,
    S_END
  } state_e;

  // Transaction configuration captured when start is accepted.
  typedef struct packed {
    logic [5:0]  cmd_len;
    logic [31:0] cmd_data;
    logic [5:0]  addr_len;
    logic [31:0] addr_data;
    logic [15:0] dummy_len;
    logic [15:0] data_len;   // already masked to whole nibbles in quad mode
    logic        quad;
    logic [1:0]  cs_sel;
  } cfg_t;

  function automatic logic [5:0] clamp32(input logic [5:0] len);
    return (len > 6'd32) ? 6'd32 : len;
  endfunction

  // Number of 32-bit words needed to cover len bits (ceiling division).
  function automatic logic [11:0] words_for(input logic [15:0] len);
    logic [16:0] sum;
    sum = {1'b0, len} + 17'd31;
    return sum[16:5];
  endfunction

  state_e      state_q, state_d;
  cfg_t        cfg_q, cfg_d;
  logic [11:0] words_q, words_d;
  logic        done_q, done_d;

  state_e      after_cmd, after_addr, after_dummy, first_phase;
  logic        words_nz;
  logic [15:0] cmd_len16, addr_len16;

  assign words_nz   = (words_q != 12'd0);
  assign cmd_len16  = {10'd0, cfg_q.cmd_len};
  assign addr_len16 = {10'd0, cfg_q.addr_len};

  // Next non-empty phase after each phase, skipping zero-length ones.
  always_comb begin
    after_dummy = (cfg_q.data_len  != 16'd0) ? S_DATA_SETUP  : S_END;
    after_addr  = (cfg_q.dummy_len != 16'd0) ? S_DUMMY_SETUP : after_dummy;
    after_cmd   = (cfg_q.addr_len  != 6'd0)  ? S_ADDR_SETUP  : after_addr;
    first_phase = (cfg_q.cmd_len   != 6'd0)  ? S_CMD_SETUP   : after_cmd;
  end

  // Next-state, word counter and serializer-facing outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; a missing default would infer a latch.
    state_d         = state_q;
    cfg_d           = cfg_q;
    words_d         = words_q;
    done_d          = 1'b0;
    tx_en_o         = 1'b0;
    tx_en_quad_o    = 1'b0;
    tx_cnt_upd_o    = 1'b0;
    tx_cnt_o        = 16'd0;
    tx_data_o       = 32'd0;
    tx_data_valid_o = 1'b0;
    wr_ready_o      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          cfg_d.cmd_len   = clamp32(cmd_len_i);
          cfg_d.cmd_data  = cmd_data_i;
          cfg_d.addr_len  = clamp32(addr_len_i);
          cfg_d.addr_data = addr_data_i;
          cfg_d.dummy_len = dummy_len_i;
          cfg_d.data_len  = quad_en_i ? {data_len_i[15:2], 2'b00} : data_len_i;
          cfg_d.quad      = quad_en_i;
          cfg_d.cs_sel    = cs_sel_i;
          state_d         = S_LEAD;
        end
      end
      S_LEAD: state_d = first_phase;
      S_CMD_SETUP: begin
        tx_cnt_upd_o = 1'b1;
        tx_cnt_o     = cmd_len16;
        words_d      = words_for(cmd_len16);
        state_d      = S_CMD_RUN;
      end
      S_CMD_RUN: begin
        tx_en_o         = 1'b1;
        tx_cnt_o        = cmd_len16;
        tx_data_o       = cfg_q.cmd_data;
        tx_data_valid_o = words_nz;
        if (tx_done_i) state_d = after_cmd;
      end
      S_ADDR_SETUP: begin
        tx_cnt_upd_o = 1'b1;
        tx_en_quad_o = cfg_q.quad;
        tx_cnt_o     = addr_len16;
        words_d      = words_for(addr_len16);
        state_d      = S_ADDR_RUN;
      end
      S_ADDR_RUN: begin
        tx_en_o         = 1'b1;
        tx_en_quad_o    = cfg_q.quad;
        tx_cnt_o        = addr_len16;
        tx_data_o       = cfg_q.addr_data;
        tx_data_valid_o = words_nz;
        if (tx_done_i) state_d = after_addr;
      end
      S_DUMMY_SETUP: begin
        tx_cnt_upd_o = 1'b1;
        tx_cnt_o     = cfg_q.dummy_len;
        words_d      = words_for(cfg_q.dummy_len);
        state_d      = S_DUMMY_RUN;
      end
      S_DUMMY_RUN: begin
        tx_en_o         = 1'b1;
        tx_cnt_o        = cfg_q.dummy_len;
        tx_data_valid_o = words_nz;
        if (tx_done_i) state_d = after_dummy;
      end
      S_DATA_SETUP: begin
        tx_cnt_upd_o = 1'b1;
        tx_en_quad_o = cfg_q.quad;
        tx_cnt_o     = cfg_q.data_len;
        words_d      = words_for(cfg_q.data_len);
        state_d      = S_DATA_RUN;
      end
      S_DATA_RUN: begin
        tx_en_o         = 1'b1;
        tx_en_quad_o    = cfg_q.quad;
        tx_cnt_o        = cfg_q.data_len;
        tx_data_o       = wr_data_i;
        tx_data_valid_o = wr_valid_i && words_nz;
        wr_ready_o      = tx_data_ready_i && words_nz;
        if (tx_done_i) state_d = S_END;
      end
      S_END: begin
        state_d = S_IDLE;
        words_d = 12'd0;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // One word consumed per serializer handshake during a run sub-state.
    if (tx_en_o && tx_data_valid_o && tx_data_ready_i) words_d = words_q - 12'd1;

    // Abort wins over everything once a transaction is in flight.
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      words_d = 12'd0;
      done_d  = 1'b0;
    end
  end

  // State, configuration, word counter and completion pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cfg_q   <= '0;
      words_q <= 12'd0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      cfg_q   <= cfg_d;
      words_q <= words_d;
      done_q  <= done_d;
    end
  end

  // Exactly one chip select low for the whole non-idle transaction.
  always_comb begin
    csn_o = 4'hF;
    if (state_q != S_IDLE) csn_o[cfg_q.cs_sel] = 1'b0;
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: a reference model expands each
// transaction into the ordered serializer events it must produce (setup
// records, words, completion); a monitor compares DUT activity against them.
module tb_spi_xfer_ctrl;

  typedef enum int {K_SETUP, K_WORD, K_DONE} kind_e;
  typedef enum int {P_CMD, P_ADDR, P_DUMMY, P_DATA} phase_e;

  typedef struct {
    kind_e       kind;
    phase_e      phase;
    int          cnt;    // setup: length; done: 1 if latency is checked
    bit          quad;
    logic [31:0] data;
  } ev_t;

  typedef struct {
    int          cmd_len;
    logic [31:0] cmd_data;
    int          addr_len;
    logic [31:0] addr_data;
    int          dummy_len;
    int          data_len;
    bit          quad;
    int          cs;
  } tcfg_t;

  logic        clk, rst;
  logic        start_i, abort_i;
  logic [5:0]  cmd_len_i, addr_len_i;
  logic [31:0] cmd_data_i, addr_data_i;
  logic [15:0] dummy_len_i, data_len_i;
  logic        quad_en_i;
  logic [1:0]  cs_sel_i;
  logic [31:0] wr_data_i;
  logic        wr_valid_i, wr_ready_o;
  logic        tx_en_o, tx_en_quad_o, tx_cnt_upd_o;
  logic [15:0] tx_cnt_o;
  logic [31:0] tx_data_o;
  logic        tx_data_valid_o, tx_data_ready_i, tx_done_i;
  logic [3:0]  csn_o;
  logic        busy_o, done_o;

  spi_xfer_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .cmd_len_i(cmd_len_i), .cmd_data_i(cmd_data_i),
    .addr_len_i(addr_len_i), .addr_data_i(addr_data_i),
    .dummy_len_i(dummy_len_i), .data_len_i(data_len_i),
    .quad_en_i(quad_en_i), .cs_sel_i(cs_sel_i),
    .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .tx_en_o(tx_en_o), .tx_en_quad_o(tx_en_quad_o), .tx_cnt_upd_o(tx_cnt_upd_o),
    .tx_cnt_o(tx_cnt_o), .tx_data_o(tx_data_o), .tx_data_valid_o(tx_data_valid_o),
    .tx_data_ready_i(tx_data_ready_i), .tx_done_i(tx_done_i),
    .csn_o(csn_o), .busy_o(busy_o), .done_o(done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  ev_t         exp_q[$];
  logic [31:0] prod_q[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, last_done_cyc = -100;
  int csn_low_cnt = 0, en_cnt = 0, wr_hs = 0;
  int exp_words = 0, stall_cnt = 0;
  bit zero_txn = 0;
  logic [1:0] cur_cs = 2'd0;
  phase_e cur_phase = P_CMD;
  bit cur_quad = 0;
  int left = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ceil32(input int n);
    return (n + 31) / 32;
  endfunction

  function automatic void push_ev(input kind_e k, input phase_e p, input int cnt,
                                  input bit q, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.phase = p; e.cnt = cnt; e.quad = q; e.data = d;
    exp_q.push_back(e);
  endfunction

  // Serializer model: accepts words with random readiness and pulses tx_done
  // once every word of the announced length has been taken.
  initial begin
    int target, acc;
    bit sent;
    target = 0; acc = 0; sent = 1;
    tx_done_i = 1'b0; tx_data_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_cnt_upd_o) begin
        target = ceil32(int'(tx_cnt_o)); acc = 0; sent = 0;
      end
      if (tx_en_o && tx_data_valid_o && tx_data_ready_i) acc++;
      @(posedge clk); #1;
      if (!sent && tx_en_o && acc == target && $urandom_range(0, 2) != 0) begin
        tx_done_i = 1'b1; sent = 1;
      end else begin
        tx_done_i = 1'b0;
      end
      tx_data_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // Upstream producer: offers queued data words with random gaps.
  initial begin
    wr_valid_i = 1'b0; wr_data_i = 32'd0;
    forever begin
      @(negedge clk);
      if (wr_valid_i && wr_ready_o && prod_q.size() > 0) void'(prod_q.pop_front());
      @(posedge clk); #1;
      if (stall_cnt > 0) begin
        stall_cnt--;
        wr_valid_i = 1'b0;
      end else begin
        wr_valid_i = (prod_q.size() > 0) && ($urandom_range(0, 3) != 0);
      end
      wr_data_i = (prod_q.size() > 0) ? prod_q[0] : $urandom;
    end
  end

  // Monitor: compares every DUT output event against the scoreboard.
  always @(negedge clk) begin : mon
    ev_t e;
    logic [3:0] csn_exp;
    bit v_exp, r_exp;
    if (!rst) begin
      cyc++;
      if (tx_done_i) last_done_cyc = cyc;
      if (csn_o != 4'hF) csn_low_cnt++;
      if (tx_en_o) en_cnt++;
      if (wr_valid_i && wr_ready_o) wr_hs++;
      csn_exp = 4'hF;
      if (busy_o) csn_exp[cur_cs] = 1'b0;
      check("csn", csn_o, csn_exp);

      if (tx_cnt_upd_o) begin
        check("upd_while_en", tx_en_o, 0);
        check("setup_valid", tx_data_valid_o, 0);
        check("setup_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("setup_kind", e.kind, K_SETUP);
          check("setup_cnt", tx_cnt_o, e.cnt);
          check("setup_quad", tx_en_quad_o, e.quad);
          cur_phase = e.phase; cur_quad = e.quad; left = ceil32(e.cnt);
        end
      end

      if (tx_en_o) begin
        check("run_quad", tx_en_quad_o, cur_quad);
        v_exp = (left != 0) && (cur_phase != P_DATA || wr_valid_i);
        check("run_valid", tx_data_valid_o, v_exp);
        r_exp = (cur_phase == P_DATA) && tx_data_ready_i && (left != 0);
        check("wr_ready", wr_ready_o, r_exp);
        if (tx_data_valid_o && tx_data_ready_i) begin
          check("word_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("word_kind", e.kind, K_WORD);
            check("word_data", tx_data_o, e.data);
            if (left > 0) left--;
          end
        end
      end else begin
        check("idle_valid", tx_data_valid_o, 0);
        check("idle_wr_ready", wr_ready_o, 0);
      end

      if (done_o) begin
        check("done_busy", busy_o, 0);
        check("done_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("done_kind", e.kind, K_DONE);
          if (e.cnt == 1) check("done_latency", cyc - last_done_cyc, 2);
        end
      end
    end
  end

  // Reference model: expand a configuration into its expected event list.
  task automatic launch(input tcfg_t c);
    int cl, al, dt, n;
    logic [31:0] w;
    cl = (c.cmd_len > 32) ? 32 : c.cmd_len;
    al = (c.addr_len > 32) ? 32 : c.addr_len;
    dt = c.quad ? (c.data_len / 4) * 4 : c.data_len;
    for (int i = 0; i < 5000 && busy_o; i++) @(posedge clk);
    #1;
    cmd_len_i = 6'(c.cmd_len);       cmd_data_i = c.cmd_data;
    addr_len_i = 6'(c.addr_len);     addr_data_i = c.addr_data;
    dummy_len_i = 16'(c.dummy_len);  data_len_i = 16'(c.data_len);
    quad_en_i = c.quad;              cs_sel_i = 2'(c.cs);
    start_i = 1'b1;
    cur_cs = 2'(c.cs);
    csn_low_cnt = 0; en_cnt = 0; wr_hs = 0;
    if (cl != 0) begin
      push_ev(K_SETUP, P_CMD, cl, 0, 0);
      push_ev(K_WORD, P_CMD, 0, 0, c.cmd_data);
    end
    if (al != 0) begin
      push_ev(K_SETUP, P_ADDR, al, c.quad, 0);
      push_ev(K_WORD, P_ADDR, 0, 0, c.addr_data);
    end
    if (c.dummy_len != 0) begin
      push_ev(K_SETUP, P_DUMMY, c.dummy_len, 0, 0);
      for (int i = 0; i < ceil32(c.dummy_len); i++) push_ev(K_WORD, P_DUMMY, 0, 0, 32'd0);
    end
    n = 0;
    if (dt != 0) begin
      push_ev(K_SETUP, P_DATA, dt, c.quad, 0);
      n = ceil32(dt);
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        prod_q.push_back(w);
        push_ev(K_WORD, P_DATA, 0, 0, w);
      end
    end
    zero_txn = (cl == 0 && al == 0 && c.dummy_len == 0 && dt == 0);
    exp_words = n;
    push_ev(K_DONE, P_CMD, zero_txn ? 0 : 1, 0, 0);
    @(posedge clk); #1;
    start_i = 1'b0;
    // Scramble the live inputs: the DUT must work from its captured copy.
    cmd_len_i = 6'($urandom); cmd_data_i = $urandom; addr_len_i = 6'($urandom);
    addr_data_i = $urandom; dummy_len_i = 16'($urandom); data_len_i = 16'($urandom);
    quad_en_i = 1'($urandom); cs_sel_i = 2'($urandom);
  endtask

  task automatic finish_txn();
    int i;
    for (i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done_o) break;
    end
    check("done_within_budget", i < 4000, 1);
    @(posedge clk); #1;
    check("events_drained", exp_q.size(), 0);
    check("wr_handshakes", wr_hs, exp_words);
    if (zero_txn) begin
      check("zero_csn_cycles", csn_low_cnt, 2);
      check("zero_no_tx_en", en_cnt, 0);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {csn_o, busy_o, done_o, tx_en_o, tx_en_quad_o, tx_cnt_upd_o,
                 tx_data_valid_o, wr_ready_o, tx_cnt_o, tx_data_o},
          {4'hF, 7'b0, 16'h0, 32'h0});
  endtask

  task automatic flush();
    exp_q.delete();
    prod_q.delete();
  endtask

  tcfg_t c;

  initial begin
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    cmd_len_i = '0; cmd_data_i = '0; addr_len_i = '0; addr_data_i = '0;
    dummy_len_i = '0; data_len_i = '0; quad_en_i = 1'b0; cs_sel_i = '0;
    @(negedge clk);
    check_reset_outputs("reset_outputs");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single 8-bit command on chip select 1.
    c = '{cmd_len: 8, cmd_data: 32'h9F00_0000, addr_len: 0, addr_data: 0,
          dummy_len: 0, data_len: 0, quad: 0, cs: 1};
    launch(c);
    @(negedge clk);
    check("cmd_only_csn", csn_o, 4'b1101);
    finish_txn();

    // Full quad transaction: cmd 8, addr 24, dummy 8, data 64.
    c = '{cmd_len: 8, cmd_data: 32'hEB00_0000, addr_len: 24, addr_data: 32'h1234_5600,
          dummy_len: 8, data_len: 64, quad: 1, cs: 2};
    launch(c);
    finish_txn();

    // All lengths zero.
    c = '{cmd_len: 0, cmd_data: 0, addr_len: 0, addr_data: 0,
          dummy_len: 0, data_len: 0, quad: 0, cs: 3};
    launch(c);
    finish_txn();

    // Quad data shorter than a nibble collapses to nothing.
    c = '{cmd_len: 0, cmd_data: 0, addr_len: 0, addr_data: 0,
          dummy_len: 0, data_len: 3, quad: 1, cs: 0};
    launch(c);
    finish_txn();

    // Start together with abort in IDLE is dropped.
    @(posedge clk); #1;
    cmd_len_i = 6'd8; start_i = 1'b1; abort_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; abort_i = 1'b0;
    check("start_abort_idle_busy", busy_o, 0);
    check("start_abort_idle_csn", csn_o, 4'hF);

    // Abort during DATA after the first word.
    c = '{cmd_len: 8, cmd_data: 32'h0200_0000, addr_len: 0, addr_data: 0,
          dummy_len: 0, data_len: 128, quad: 0, cs: 1};
    launch(c);
    for (int i = 0; i < 2000 && wr_hs < 1; i++) @(negedge clk);
    check("abort_first_word_seen", wr_hs >= 1, 1);
    @(posedge clk); #1;
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    flush();
    check("abort_csn", csn_o, 4'hF);
    check("abort_tx_en", tx_en_o, 0);
    check("abort_wr_ready", wr_ready_o, 0);
    check("abort_busy", busy_o, 0);
    repeat (4) begin
      @(negedge clk);
      check("abort_no_done", done_o, 0);
    end

    // Upstream stall of 5 cycles in the middle of DATA.
    c = '{cmd_len: 8, cmd_data: 32'h3B00_0000, addr_len: 0, addr_data: 0,
          dummy_len: 0, data_len: 160, quad: 0, cs: 0};
    launch(c);
    for (int i = 0; i < 2000 && wr_hs < 2; i++) @(negedge clk);
    check("stall_two_words_seen", wr_hs >= 2, 1);
    stall_cnt = 5;
    finish_txn();

    // Asynchronous reset while ADDR is running, then a normal transaction.
    c = '{cmd_len: 0, cmd_data: 0, addr_len: 24, addr_data: 32'hABCD_EF00,
          dummy_len: 0, data_len: 32, quad: 1, cs: 3};
    launch(c);
    for (int i = 0; i < 2000 && !tx_en_o; i++) @(negedge clk);
    check("addr_run_reached", tx_en_o, 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset_outputs");
    flush();
    @(posedge clk); #1;
    rst = 1'b0;
    c = '{cmd_len: 8, cmd_data: 32'h0300_0000, addr_len: 24, addr_data: 32'h0010_2000,
          dummy_len: 0, data_len: 40, quad: 0, cs: 2};
    launch(c);
    finish_txn();

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      c.cmd_len   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 63);
      c.cmd_data  = $urandom;
      c.addr_len  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 63);
      c.addr_data = $urandom;
      c.dummy_len = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 70);
      c.data_len  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(1, 200);
      c.quad      = 1'($urandom_range(0, 1));
      c.cs        = $urandom_range(0, 3);
      launch(c);
      finish_txn();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
